// File: rtl/mem_stage_pkg.sv
// Shared constants and payload layouts for the memory stage.
package mem_stage_pkg;

    localparam int unsigned ToMemDataWidth  = 76;
    localparam int unsigned ToWbDataWidth   = 72;
    localparam int unsigned MemForwardWidth = 37;

    // Execute-to-memory payload, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        rd_1_byte;
        logic        rd_2_byte;
        logic        rd_4_byte;
        logic        rd_signed;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ex_sys;
        logic        is_ertn;
    } ex_mem_t;

    // Memory-to-writeback payload, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ex_sys;
        logic        is_ertn;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Byte/half lane select and sign/zero extension of a load word.
module load_align (
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  addr_i,
    input  logic        size_1_i,
    input  logic        size_2_i,
    input  logic        size_4_i,
    input  logic        signed_i,
    output logic [31:0] value_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed lane and extend it according to the access size.
    always_comb begin
        unique case (addr_i)
            2'd0:    sel_byte = rd_word_i[7:0];
            2'd1:    sel_byte = rd_word_i[15:8];
            2'd2:    sel_byte = rd_word_i[23:16];
            default: sel_byte = rd_word_i[31:24];
        endcase
        sel_half = addr_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

        value_o = rd_word_i;
        if (size_1_i) begin
            value_o = {{24{signed_i & sel_byte[7]}}, sel_byte};
        end else if (size_2_i) begin
            value_o = {{16{signed_i & sel_half[15]}}, sel_half};
        end else if (size_4_i) begin
            value_o = rd_word_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: latches the execute payload, aligns load data and
// keeps the SRAM read word alive across writeback stalls.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       csr_reset,
    input  logic                       WB_allow_in,
    input  logic                       EX_to_MEM_valid,
    input  logic [ToMemDataWidth-1:0]  to_MEM_data,
    input  logic [31:0]                data_sram_rdata,
    output logic                       MEM_allow_in,
    output logic                       MEM_to_WB_valid,
    output logic [ToWbDataWidth-1:0]   to_WB_data,
    output logic [MemForwardWidth-1:0] MEM_forward
);

    localparam logic MemReadyGo = 1'b1;

    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    ex_mem_t     payload_q, payload_d;

    logic        accept;
    logic        is_load;
    logic [31:0] rd_word;
    logic [31:0] load_value;
    logic [31:0] final_result;
    mem_wb_t     wb_data;

    // Handshake and next-state for valid, payload and the read hold buffer.
    always_comb begin
        MEM_allow_in = ~valid_q | (MemReadyGo & WB_allow_in);
        accept       = EX_to_MEM_valid & MEM_allow_in;

        valid_d = valid_q;
        if (MEM_allow_in) begin
            valid_d = EX_to_MEM_valid;
        end

        payload_d = accept ? ex_mem_t'(to_MEM_data) : payload_q;

        // The SRAM word is only valid for one cycle; park it while WB stalls.
        held_d      = held_q;
        rdata_buf_d = rdata_buf_q;
        if (accept || (valid_q && WB_allow_in)) begin
            held_d = 1'b0;
        end else if (valid_q && !held_q && !WB_allow_in) begin
            held_d      = 1'b1;
            rdata_buf_d = data_sram_rdata;
        end
    end

    // Control state; csr_reset flushes the stage like reset.
    always_ff @(posedge clk) begin
        if (reset || csr_reset) begin
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    // Hold buffer data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_q <= '0;
        end else begin
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Payload register; contents are qualified by valid_q, so no reset.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign rd_word = held_q ? rdata_buf_q : data_sram_rdata;
    assign is_load = payload_q.rd_1_byte | payload_q.rd_2_byte | payload_q.rd_4_byte;

    load_align u_load_align (
        .rd_word_i (rd_word),
        .addr_i    (payload_q.alu_result[1:0]),
        .size_1_i  (payload_q.rd_1_byte),
        .size_2_i  (payload_q.rd_2_byte),
        .size_4_i  (payload_q.rd_4_byte),
        .signed_i  (payload_q.rd_signed),
        .value_o   (load_value)
    );

    // Writeback payload and decode-stage bypass.
    always_comb begin
        final_result         = is_load ? load_value : payload_q.alu_result;
        wb_data.pc           = payload_q.pc;
        wb_data.final_result = final_result;
        wb_data.dest         = payload_q.dest;
        wb_data.gr_we        = payload_q.gr_we;
        wb_data.ex_sys       = payload_q.ex_sys;
        wb_data.is_ertn      = payload_q.is_ertn;
        to_WB_data           = wb_data;
        MEM_to_WB_valid      = valid_q;
        MEM_forward          = {payload_q.dest & {5{valid_q & payload_q.gr_we}}, final_result};
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback/forward
// values, a negedge monitor pops them on every handoff to writeback.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, csr_reset, WB_allow_in, EX_to_MEM_valid;
    logic [75:0] to_MEM_data;
    logic [31:0] data_sram_rdata;
    logic        MEM_allow_in, MEM_to_WB_valid;
    logic [71:0] to_WB_data;
    logic [36:0] MEM_forward;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .csr_reset       (csr_reset),
        .WB_allow_in     (WB_allow_in),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .to_MEM_data     (to_MEM_data),
        .data_sram_rdata (data_sram_rdata),
        .MEM_allow_in    (MEM_allow_in),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .to_WB_data      (to_WB_data),
        .MEM_forward     (MEM_forward)
    );

    typedef struct packed {
        logic [71:0] wb;
        logic [36:0] fwd;
    } exp_t;

    exp_t q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   pushes   = 0;
    int   handoffs = 0;

    // {rd_1_byte, rd_2_byte, rd_4_byte, rd_signed}
    localparam logic [3:0] None = 4'b0000;
    localparam logic [3:0] Lw   = 4'b0010;
    localparam logic [3:0] Lb   = 4'b1001;
    localparam logic [3:0] Lbu  = 4'b1000;
    localparam logic [3:0] Lh   = 4'b0101;
    localparam logic [3:0] Lhu  = 4'b0100;

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                       input logic [3:0] rd, input logic [4:0] dest,
                                       input logic we);
        return {pc, alu, rd, dest, we, 2'b00};
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                        input logic we);
        exp_t e;
        e.wb  = {pc, res, dest, we, 2'b00};
        e.fwd = {(we ? dest : 5'd0), res};
        q.push_back(e);
        pushes++;
    endtask

    // One cycle of stimulus, applied just after the rising edge; returns at the falling edge.
    task automatic drive(input logic ex_v, input logic [75:0] d, input logic [31:0] rd,
                         input logic wb, input logic csr);
        @(posedge clk);
        #1;
        EX_to_MEM_valid = ex_v;
        to_MEM_data     = d;
        data_sram_rdata = rd;
        WB_allow_in     = wb;
        csr_reset       = csr;
        @(negedge clk);
    endtask

    // Monitor: compare on handoff, and check the held result during stalls.
    always @(negedge clk) begin
        if (!reset && MEM_to_WB_valid) begin
            if (WB_allow_in) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {4'd0, to_WB_data}, 76'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    handoffs++;
                    chk("to_WB_data", {4'd0, to_WB_data}, {4'd0, e.wb});
                    chk("MEM_forward", {39'd0, MEM_forward}, {39'd0, e.fwd});
                end
            end else if (q.size() != 0) begin
                chk("stall_result", {44'd0, to_WB_data[39:8]}, {44'd0, q[0].wb[39:8]});
            end
        end
    end

    initial begin
        reset           = 1'b1;
        csr_reset       = 1'b0;
        WB_allow_in     = 1'b1;
        EX_to_MEM_valid = 1'b0;
        to_MEM_data     = '0;
        data_sram_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", {75'd0, MEM_to_WB_valid}, 76'd0);
        chk("rst_allow_in", {75'd0, MEM_allow_in}, 76'd1);
        chk("rst_fwd_dest", {71'd0, MEM_forward[36:32]}, 76'd0);

        // ld.w, no stall
        push(32'h100, 32'hDEADBEEF, 5'd4, 1'b1);
        drive(1, mk(32'h100, 32'h1000, Lw, 5'd4, 1'b1), 32'h0, 1, 0);
        drive(0, '0, 32'hDEADBEEF, 1, 0);

        // Pipelined byte/half loads
        push(32'h104, 32'hFFFFFF80, 5'd6, 1'b1);
        push(32'h108, 32'h00000080, 5'd7, 1'b1);
        push(32'h10C, 32'hFFFF8001, 5'd8, 1'b1);
        push(32'h110, 32'h00001234, 5'd9, 1'b1);
        push(32'h114, 32'h0000007F, 5'd10, 1'b1);
        drive(1, mk(32'h104, 32'h1003, Lb,  5'd6,  1'b1), 32'h0, 1, 0);
        drive(1, mk(32'h108, 32'h1003, Lbu, 5'd7,  1'b1), 32'h80FF0000, 1, 0);
        drive(1, mk(32'h10C, 32'h1002, Lh,  5'd8,  1'b1), 32'h80FF0000, 1, 0);
        drive(1, mk(32'h110, 32'h1000, Lhu, 5'd9,  1'b1), 32'h80011234, 1, 0);
        drive(1, mk(32'h114, 32'h1001, Lb,  5'd10, 1'b1), 32'h80011234, 1, 0);
        drive(0, '0, 32'h00007F00, 1, 0);

        // add then st.w back to back
        push(32'h200, 32'h7, 5'd5, 1'b1);
        push(32'h204, 32'h2000, 5'd3, 1'b0);
        drive(1, mk(32'h200, 32'h7, None, 5'd5, 1'b1), 32'h0, 1, 0);
        drive(1, mk(32'h204, 32'h2000, None, 5'd3, 1'b0), 32'h0, 1, 0);
        chk("no_bubble_1", {75'd0, MEM_to_WB_valid}, 76'd1);
        drive(0, '0, 32'h0, 1, 0);
        chk("no_bubble_2", {75'd0, MEM_to_WB_valid}, 76'd1);

        // ld.w stalled three cycles; SRAM word changes after the first
        push(32'h300, 32'h12345678, 5'd7, 1'b1);
        drive(1, mk(32'h300, 32'h3000, Lw, 5'd7, 1'b1), 32'h0, 1, 0);
        drive(0, '0, 32'h12345678, 0, 0);
        chk("stall_allow_in", {75'd0, MEM_allow_in}, 76'd0);
        drive(0, '0, 32'h0, 0, 0);
        drive(0, '0, 32'h0, 0, 0);
        drive(0, '0, 32'h0, 1, 0);

        // csr_reset during a stall drops the instruction
        drive(1, mk(32'h400, 32'h4000, Lw, 5'd9, 1'b1), 32'h0, 1, 0);
        drive(0, '0, 32'hAAAA5555, 0, 0);
        drive(0, '0, 32'h0, 0, 1);
        drive(0, '0, 32'h0, 0, 0);
        chk("flush_valid", {75'd0, MEM_to_WB_valid}, 76'd0);
        chk("flush_fwd_dest", {71'd0, MEM_forward[36:32]}, 76'd0);
        chk("flush_allow_in", {75'd0, MEM_allow_in}, 76'd1);
        drive(0, '0, 32'h0, 1, 0);

        // Hold buffer must not leak into the next load after a flush
        push(32'h500, 32'hCAFEF00D, 5'd12, 1'b1);
        drive(1, mk(32'h500, 32'h5000, Lw, 5'd12, 1'b1), 32'h0, 1, 0);
        drive(0, '0, 32'hCAFEF00D, 1, 0);

        // Leave and accept in the same cycle after a stall
        push(32'h600, 32'h11111111, 5'd10, 1'b1);
        push(32'h604, 32'h22222222, 5'd11, 1'b1);
        drive(1, mk(32'h600, 32'h6000, Lw, 5'd10, 1'b1), 32'h0, 1, 0);
        drive(0, '0, 32'h11111111, 0, 0);
        drive(1, mk(32'h604, 32'h6004, Lw, 5'd11, 1'b1), 32'h0, 1, 0);
        drive(0, '0, 32'h22222222, 1, 0);

        repeat (3) drive(0, '0, 32'h0, 1, 0);
        chk("queue_drained", 76'(q.size()), 76'd0);
        chk("handoff_count", 76'(handoffs), 76'(pushes));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
